// File: rtl/hdmi_clken_gen.sv
// Lock-qualified multi-channel fractional clock-enable generator (phase accumulators, staggered channel resets).
// Latency: lock seen LOCK_SYNC+1 edges after pll_locked; ch_rst[0] drops LOCK_HOLD edges later; ce registered 1 cycle after wrap.
// Backpressure: cfg_ready drops for exactly one cycle after each accepted increment write; no other flow control.
//
// Ports: inclk0/rst         - sole clock, async active-high reset
//        pll_locked         - raw PLL lock, asynchronous to inclk0
//        cfg_valid/ready/ch/inc - per-channel increment write (cfg_ch >= NCH is accepted and dropped)
//        ce, ch_rst         - per-channel enable pulses and active-high consumer resets
//        ready, relock_cnt  - all channels released; saturating count of lock losses from RUN
module hdmi_clken_gen #(
    parameter int          NCH         = 3,
    parameter int          ACC_W       = 24,
    parameter int unsigned INC_INIT    = 2**23,
    parameter int          LOCK_SYNC   = 2,
    parameter int          LOCK_HOLD   = 1024,
    parameter int          RST_STAGGER = 16,
    localparam int         CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             inclk0,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [ACC_W-1:0] cfg_inc,
    output logic [NCH-1:0]   ce,
    output logic [NCH-1:0]   ch_rst,
    output logic             ready,
    output logic [7:0]       relock_cnt
);

    // One counter serves both the lock-hold window and the release stagger.
    localparam int REL_MAX = (NCH - 1) * RST_STAGGER;
    localparam int CNT_MAX = (LOCK_HOLD > REL_MAX) ? LOCK_HOLD : REL_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LOCK_HOLD - 1);

    typedef enum logic [1:0] {WAIT_LOCK, HOLD, RELEASE, RUN} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [NCH-1:0]       ch_rst_nxt;
    logic                 ready_nxt;
    logic [7:0]           relock_nxt;
    logic [LOCK_SYNC-1:0] lk_sync;
    logic                 lk_s;

    logic [ACC_W-1:0]     acc [NCH];
    logic [ACC_W-1:0]     inc [NCH];
    logic [ACC_W:0]       sum [NCH];
    logic                 cfg_acc;

    assign lk_s    = lk_sync[LOCK_SYNC-1];
    assign cfg_acc = cfg_valid & cfg_ready;

    always_ff @(posedge inclk0 or posedge rst) begin
        if (rst) begin
            lk_sync <= '0;
        end else begin
            lk_sync <= {lk_sync[LOCK_SYNC-2:0], pll_locked};
        end
    end

    always_ff @(posedge inclk0 or posedge rst) begin
        if (rst) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            ch_rst     <= '1;
            ready      <= 1'b0;
            relock_cnt <= 8'd0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ch_rst     <= ch_rst_nxt;
            ready      <= ready_nxt;
            relock_cnt <= relock_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        ch_rst_nxt = ch_rst;
        ready_nxt  = ready;
        relock_nxt = relock_cnt;
        case (state)
            WAIT_LOCK: begin
                ch_rst_nxt = '1;
                ready_nxt  = 1'b0;
                if (lk_s) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end
            end
            HOLD: begin
                if (!lk_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == HOLD_LAST) begin
                    // Channel 0 leaves reset on the edge that ends the hold window.
                    cnt_nxt       = '0;
                    ch_rst_nxt[0] = 1'b0;
                    state_nxt     = (NCH == 1) ? RUN : RELEASE;
                    ready_nxt     = (NCH == 1);
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (!lk_s) begin
                    state_nxt  = WAIT_LOCK;
                    ch_rst_nxt = '1;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    for (int k = 1; k < NCH; k++) begin
                        if (cnt_nxt == CNT_W'(k * RST_STAGGER)) begin
                            ch_rst_nxt[k] = 1'b0;
                        end
                    end
                    if (cnt_nxt == CNT_W'(REL_MAX)) begin
                        state_nxt = RUN;
                        ready_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!lk_s) begin
                    state_nxt  = WAIT_LOCK;
                    ch_rst_nxt = '1;
                    ready_nxt  = 1'b0;
                    if (relock_cnt != 8'hFF) begin
                        relock_nxt = relock_cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_nxt  = WAIT_LOCK;
                ch_rst_nxt = '1;
                ready_nxt  = 1'b0;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
        end
    end

    // Accumulators are cleared on the same edge a channel enters reset, so a
    // lock loss stops ce immediately rather than one cycle later.
    always_ff @(posedge inclk0 or posedge rst) begin
        if (rst) begin
            cfg_ready <= 1'b1;
            ce        <= '0;
            for (int i = 0; i < NCH; i++) begin
                acc[i] <= '0;
                inc[i] <= ACC_W'(INC_INIT);
            end
        end else begin
            cfg_ready <= ~cfg_acc;
            for (int i = 0; i < NCH; i++) begin
                if (ch_rst_nxt[i]) begin
                    acc[i] <= '0;
                    ce[i]  <= 1'b0;
                end else if (!ch_rst[i]) begin
                    acc[i] <= sum[i][ACC_W-1:0];
                    ce[i]  <= sum[i][ACC_W];
                end else begin
                    ce[i]  <= 1'b0;
                end
                // Out-of-range channel numbers match no slot and are dropped.
                if (cfg_acc && cfg_ch == CH_W'(i)) begin
                    inc[i] <= cfg_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_hdmi_clken_gen.sv
module tb_hdmi_clken_gen;

    localparam int NCH       = 3;
    localparam int ACC_W     = 8;
    localparam int INC_INIT  = 128;
    localparam int LOCK_SYNC = 2;
    localparam int LOCK_HOLD = 8;
    localparam int STAG      = 4;
    localparam int RUN_AT    = LOCK_HOLD + (NCH - 1) * STAG;

    logic             inclk0;
    logic             rst;
    logic             pll_locked;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic [ACC_W-1:0] cfg_inc;
    logic [NCH-1:0]   ce;
    logic [NCH-1:0]   ch_rst;
    logic             ready;
    logic [7:0]       relock_cnt;

    hdmi_clken_gen #(
        .NCH(NCH), .ACC_W(ACC_W), .INC_INIT(INC_INIT),
        .LOCK_SYNC(LOCK_SYNC), .LOCK_HOLD(LOCK_HOLD), .RST_STAGGER(STAG)
    ) dut (
        .inclk0(inclk0), .rst(rst), .pll_locked(pll_locked),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc),
        .ce(ce), .ch_rst(ch_rst), .ready(ready), .relock_cnt(relock_cnt)
    );

    initial inclk0 = 1'b0;
    always #5 inclk0 = ~inclk0;

    int n_tests;
    int n_fail;

    // Reference model: m_seq is the number of consecutive locked edges since
    // sequencing began (-1 while waiting for lock); the channel resets and
    // ready are simple thresholds on it. Each channel's phase is an unbounded
    // running total, and ce marks a crossing of a 2^ACC_W boundary.
    int           m_seq;
    int           m_relock;
    bit           m_cfg_rdy;
    int           m_inc [NCH];
    longint       m_phase [NCH];
    bit [NCH-1:0] m_ce;
    bit           pl_q [$];

    function automatic bit [NCH-1:0] rst_vec(int seq);
        bit [NCH-1:0] v;
        for (int k = 0; k < NCH; k++) v[k] = !(seq >= LOCK_HOLD + k * STAG);
        return v;
    endfunction

    task automatic model_reset();
        m_seq     = -1;
        m_relock  = 0;
        m_cfg_rdy = 1'b1;
        m_ce      = '0;
        pl_q.delete();
        for (int k = 0; k < LOCK_SYNC; k++) pl_q.push_back(1'b0);
        for (int k = 0; k < NCH; k++) begin
            m_inc[k]   = INC_INIT;
            m_phase[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit           lk;
        bit           acc_now;
        bit [NCH-1:0] old_r;
        bit [NCH-1:0] new_r;
        lk = pl_q.pop_front();
        pl_q.push_back(pll_locked);
        old_r = rst_vec(m_seq);
        if (m_seq < 0) begin
            if (lk) m_seq = 0;
        end else if (!lk) begin
            if (m_seq >= RUN_AT && m_relock < 255) m_relock++;
            m_seq = -1;
        end else if (m_seq < RUN_AT) begin
            m_seq++;
        end
        new_r = rst_vec(m_seq);
        for (int k = 0; k < NCH; k++) begin
            if (new_r[k]) begin
                m_phase[k] = 0;
                m_ce[k]    = 1'b0;
            end else if (!old_r[k]) begin
                m_ce[k]     = ((m_phase[k] + m_inc[k]) >> ACC_W) != (m_phase[k] >> ACC_W);
                m_phase[k] += m_inc[k];
            end else begin
                m_ce[k] = 1'b0;
            end
        end
        acc_now = cfg_valid && m_cfg_rdy;
        if (acc_now && int'(cfg_ch) < NCH) m_inc[cfg_ch] = int'(cfg_inc);
        m_cfg_rdy = !acc_now;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ce",         32'(ce),         32'(m_ce));
        chk("ch_rst",     32'(ch_rst),     32'(rst_vec(m_seq)));
        chk("ready",      32'(ready),      32'(m_seq >= RUN_AT));
        chk("relock_cnt", 32'(relock_cnt), 32'(m_relock));
        chk("cfg_ready",  32'(cfg_ready),  32'(m_cfg_rdy));
    endtask

    task automatic tick();
        @(posedge inclk0);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic cfg_write(input int ch, input int val);
        bit took;
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_inc   = ACC_W'(val);
        for (int g = 0; g < 4; g++) begin
            took = m_cfg_rdy;
            tick();
            if (took) break;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int g;
        g = 0;
        while (ready !== 1'b1 && g < 100) begin
            tick();
            g++;
        end
        chk(tag, 32'(ready), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0, d1, d2, rd, fc;
        int c0, c1, c2, g, nd;

        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        pll_locked = 1'b0;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_inc    = '0;
        model_reset();

        // Reset state
        #3;
        chk("rst_ch_rst",    32'(ch_rst),     32'h7);
        chk("rst_ready",     32'(ready),      32'd0);
        chk("rst_ce",        32'(ce),         32'd0);
        chk("rst_relock",    32'(relock_cnt), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready),  32'd1);
        @(posedge inclk0);
        #2 rst = 1'b0;
        repeat (3) tick();

        // T1: lock-up sequence timing
        pll_locked = 1'b1;
        d0 = -1; d1 = -1; d2 = -1; rd = -1; fc = -1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (d0 < 0 && ch_rst[0] === 1'b0) d0 = e;
            if (d1 < 0 && ch_rst[1] === 1'b0) d1 = e;
            if (d2 < 0 && ch_rst[2] === 1'b0) d2 = e;
            if (rd < 0 && ready === 1'b1)     rd = e;
            if (fc < 0 && ce[0] === 1'b1)     fc = e;
        end
        chk("t1_drop0",    d0, LOCK_SYNC + 1 + LOCK_HOLD);
        chk("t1_drop1",    d1, LOCK_SYNC + 1 + LOCK_HOLD + STAG);
        chk("t1_drop2",    d2, LOCK_SYNC + 1 + LOCK_HOLD + 2 * STAG);
        chk("t1_ready",    rd, LOCK_SYNC + 1 + LOCK_HOLD + 2 * STAG);
        chk("t1_first_ce", fc, LOCK_SYNC + 1 + LOCK_HOLD + 2);

        // T2: rates for inc=64, inc=0, inc=3
        cfg_write(0, 64);
        cfg_write(1, 0);
        cfg_write(2, 3);
        repeat (4) tick();
        c0 = 0; c1 = 0; c2 = 0;
        for (int n = 0; n < 1000; n++) begin
            tick();
            if (n < 256) begin
                c0 += int'(ce[0]);
                c2 += int'(ce[2]);
            end
            c1 += int'(ce[1]);
        end
        chk("t2_inc64_pulses", c0, 64);
        chk("t2_inc3_pulses",  c2, 3);
        chk("t2_inc0_pulses",  c1, 0);

        // T3: live reconfiguration and out-of-range channel
        cfg_write(1, 64);
        cfg_write(2, 64);
        repeat (8) tick();
        cfg_write(1, 128);
        chk("t3_cfg_ready_low", 32'(cfg_ready), 32'd0);
        tick();
        chk("t3_cfg_ready_back", 32'(cfg_ready), 32'd1);
        for (int pass = 0; pass < 2; pass++) begin
            c0 = 0; c1 = 0; c2 = 0;
            for (int n = 0; n < 64; n++) begin
                tick();
                c0 += int'(ce[0]);
                c1 += int'(ce[1]);
                c2 += int'(ce[2]);
            end
            chk("t3_ch0_pulses", c0, 16);
            chk("t3_ch1_pulses", c1, 32);
            chk("t3_ch2_pulses", c2, 16);
            if (pass == 0) cfg_write(3, 7);
        end
        // Random writes, including dropped valids and channel 3
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                cfg_valid = 1'b1;
                cfg_ch    = 2'($urandom_range(0, 3));
                cfg_inc   = ACC_W'($urandom);
            end else begin
                cfg_valid = 1'b0;
            end
            tick();
        end
        cfg_valid = 1'b0;

        // T4: one-cycle lock loss in RUN
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        repeat (LOCK_SYNC) tick();
        chk("t4_ch_rst", 32'(ch_rst),     32'h7);
        chk("t4_ready",  32'(ready),      32'd0);
        chk("t4_ce",     32'(ce),         32'd0);
        chk("t4_relock", 32'(relock_cnt), 32'd1);

        // T5: lock loss during HOLD
        repeat (1 + $urandom_range(1, 4)) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        repeat (2) tick();
        chk("t5_hold_ch_rst", 32'(ch_rst),     32'h7);
        chk("t5_hold_relock", 32'(relock_cnt), 32'd1);

        // T5: lock loss mid-RELEASE
        g = 0;
        while (ch_rst[0] !== 1'b0 && g < 60) begin
            tick();
            g++;
        end
        chk("t5_rel_start", 32'(ch_rst[0]), 32'd0);
        repeat ($urandom_range(0, 4)) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        repeat (2) tick();
        chk("t5_rel_ch_rst", 32'(ch_rst),     32'h7);
        chk("t5_rel_ready",  32'(ready),      32'd0);
        chk("t5_rel_relock", 32'(relock_cnt), 32'd1);
        wait_ready("t5_relock_ready");

        // T4: repeated losses until the counter saturates
        for (int i = 0; i < 258; i++) begin
            pll_locked = 1'b0;
            nd = $urandom_range(1, 3);
            repeat (nd) tick();
            pll_locked = 1'b1;
            repeat (LOCK_SYNC) tick();
            wait_ready("t4_relock_ready");
        end
        chk("t4_relock_sat", 32'(relock_cnt), 32'd255);

        // T6: async reset in RUN after writes
        cfg_write(0, 37);
        cfg_write(1, 200);
        repeat (5) tick();
        #1 rst = 1'b1;
        #1;
        chk("t6_ch_rst",    32'(ch_rst),     32'h7);
        chk("t6_ready",     32'(ready),      32'd0);
        chk("t6_ce",        32'(ce),         32'd0);
        chk("t6_relock",    32'(relock_cnt), 32'd0);
        chk("t6_cfg_ready", 32'(cfg_ready),  32'd1);
        model_reset();
        #1 rst = 1'b0;
        wait_ready("t6_ready_after");
        repeat (4) tick();
        c1 = 0;
        for (int n = 0; n < 64; n++) begin
            tick();
            c1 += int'(ce[1]);
        end
        chk("t6_inc_init_pulses", c1, 32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
